// File: rtl/flash_mp_region_ctrl_if.sv
// Requester and flash-port signals shared by the region controller and its environment.
interface flash_mp_region_ctrl_if #(
  parameter int unsigned PageW = 8
);
  logic             hw_req_i;
  logic [1:0]       hw_op_i;
  logic [PageW-1:0] hw_page_i;
  logic             hw_ack_o;
  logic             hw_err_o;

  logic             sw_req_i;
  logic [1:0]       sw_op_i;
  logic [PageW-1:0] sw_page_i;
  logic             sw_ack_o;
  logic             sw_err_o;

  logic             flash_req_o;
  logic [1:0]       flash_op_o;
  logic [PageW-1:0] flash_page_o;
  logic             flash_done_i;

  // Controller side.
  modport slave (
    input  hw_req_i, hw_op_i, hw_page_i, sw_req_i, sw_op_i, sw_page_i, flash_done_i,
    output hw_ack_o, hw_err_o, sw_ack_o, sw_err_o, flash_req_o, flash_op_o, flash_page_o
  );

  // Requesters and flash model side.
  modport master (
    output hw_req_i, hw_op_i, hw_page_i, sw_req_i, sw_op_i, sw_page_i, flash_done_i,
    input  hw_ack_o, hw_err_o, sw_ack_o, sw_err_o, flash_req_o, flash_op_o, flash_page_o
  );
endinterface

// File: rtl/flash_mp_region_ctrl.sv
// Flash memory-protection controller: arbitrates HW/SW page requests, scans data regions
// one per cycle for the first hit, and either issues the operation or answers with an error.
module flash_mp_region_ctrl #(
  parameter int unsigned NumRegions = 4,
  parameter int unsigned PageW      = 8,
  parameter bit          HwDataAttr = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  flash_mp_region_ctrl_if.slave          bus,
  input  logic [NumRegions-1:0]          region_en_i,
  input  logic [NumRegions*PageW-1:0]    region_base_i,
  input  logic [NumRegions*(PageW+1)-1:0] region_size_i,
  input  logic [NumRegions-1:0]          region_rd_en_i,
  input  logic [NumRegions-1:0]          region_prog_en_i,
  input  logic [NumRegions-1:0]          region_erase_en_i,
  output logic                           busy_o
);
  localparam int unsigned MaxRegions = 8;
  localparam int unsigned IdxW       = 3;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRegions - 1);
  // Two spare bits so base+size can never wrap.
  localparam int unsigned CmpW       = PageW + 2;

  typedef enum logic [1:0] {StIdle, StScan, StIssue, StResp} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             last_sw_q, last_sw_d;
  logic             gnt_sw_q, gnt_sw_d;
  logic [1:0]       op_q, op_d;
  logic [PageW-1:0] page_q, page_d;
  logic             err_q, err_d;

  logic [MaxRegions-1:0] hit, rd_ok, prog_ok, erase_ok;
  logic                  perm;
  logic                  pick_sw;
  logic                  resp;

  // Per-region hit/permission vectors, padded to 8 entries so idx_q indexes them directly.
  for (genvar k = 0; k < MaxRegions; k++) begin : g_region
    if (k < NumRegions) begin : g_on
      logic [CmpW-1:0] cmp_base, cmp_size, cmp_page;
      assign cmp_base    = CmpW'(region_base_i[k*PageW +: PageW]);
      assign cmp_size    = CmpW'(region_size_i[k*(PageW+1) +: PageW+1]);
      assign cmp_page    = CmpW'(page_q);
      assign hit[k]      = region_en_i[k] & (cmp_base <= cmp_page) &
                           (cmp_page < cmp_base + cmp_size);
      assign rd_ok[k]    = region_rd_en_i[k];
      assign prog_ok[k]  = region_prog_en_i[k];
      assign erase_ok[k] = region_erase_en_i[k];
    end else begin : g_off
      assign hit[k]      = 1'b0;
      assign rd_ok[k]    = 1'b0;
      assign prog_ok[k]  = 1'b0;
      assign erase_ok[k] = 1'b0;
    end
  end

  // Permission of the region under scan for the latched op; op 3 is never permitted.
  always_comb begin
    perm = 1'b0;
    case (op_q)
      2'd0:    perm = rd_ok[idx_q];
      2'd1:    perm = prog_ok[idx_q];
      2'd2:    perm = erase_ok[idx_q];
      default: perm = 1'b0;
    endcase
  end

  // Next-state logic: arbitration, region scan and issue/response sequencing.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_sw_d = last_sw_q;
    gnt_sw_d  = gnt_sw_q;
    op_d      = op_q;
    page_d    = page_q;
    err_d     = err_q;
    // SW wins when it is alone, or on a tie when HW was granted last.
    pick_sw   = bus.sw_req_i & (~bus.hw_req_i | ~last_sw_q);

    unique case (state_q)
      StIdle: begin
        if (bus.hw_req_i | bus.sw_req_i) begin
          gnt_sw_d  = pick_sw;
          last_sw_d = pick_sw;
          op_d      = pick_sw ? bus.sw_op_i : bus.hw_op_i;
          page_d    = pick_sw ? bus.sw_page_i : bus.hw_page_i;
          idx_d     = '0;
          err_d     = 1'b0;
          state_d   = StScan;
          if (HwDataAttr && !pick_sw) begin
            if (bus.hw_op_i == 2'd3) begin
              err_d   = 1'b1;
              state_d = StResp;
            end else begin
              state_d = StIssue;
            end
          end
        end
      end
      StScan: begin
        if (op_q == 2'd3) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else if (hit[idx_q]) begin
          if (perm) begin
            state_d = StIssue;
          end else begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end else if (idx_q == LastIdx) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StIssue: begin
        if (bus.flash_done_i) begin
          err_d   = 1'b0;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched request registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      last_sw_q <= 1'b1;
      gnt_sw_q  <= 1'b0;
      op_q      <= '0;
      page_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_sw_q <= last_sw_d;
      gnt_sw_q  <= gnt_sw_d;
      op_q      <= op_d;
      page_q    <= page_d;
      err_q     <= err_d;
    end
  end

  assign resp             = (state_q == StResp);
  assign bus.flash_req_o  = (state_q == StIssue);
  assign bus.flash_op_o   = op_q;
  assign bus.flash_page_o = page_q;
  assign bus.hw_ack_o     = resp & ~gnt_sw_q;
  assign bus.hw_err_o     = resp & ~gnt_sw_q & err_q;
  assign bus.sw_ack_o     = resp & gnt_sw_q;
  assign bus.sw_err_o     = resp & gnt_sw_q & err_q;
  assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_flash_mp_region_ctrl.sv
// Bench for flash_mp_region_ctrl: directed vector table, hand sequences for arbitration and
// mid-operation reset, then randomized transactions against a first-hit region model.
module tb_flash_mp_region_ctrl;
  localparam int unsigned NumRegions = 4;
  localparam int unsigned PageW      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NumRegions-1:0]           region_en, rd_en, prog_en, erase_en;
  logic [NumRegions*PageW-1:0]     region_base;
  logic [NumRegions*(PageW+1)-1:0] region_size;
  logic                            busy0, busy1;

  flash_mp_region_ctrl_if #(.PageW(PageW)) bus0 ();
  flash_mp_region_ctrl_if #(.PageW(PageW)) bus1 ();

  flash_mp_region_ctrl #(.NumRegions(NumRegions), .PageW(PageW), .HwDataAttr(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0.slave),
    .region_en_i(region_en), .region_base_i(region_base), .region_size_i(region_size),
    .region_rd_en_i(rd_en), .region_prog_en_i(prog_en), .region_erase_en_i(erase_en),
    .busy_o(busy0)
  );

  flash_mp_region_ctrl #(.NumRegions(NumRegions), .PageW(PageW), .HwDataAttr(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1.slave),
    .region_en_i(region_en), .region_base_i(region_base), .region_size_i(region_size),
    .region_rd_en_i(rd_en), .region_prog_en_i(prog_en), .region_erase_en_i(erase_en),
    .busy_o(busy1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Region configuration as plain numbers; the model reads these directly.
  bit c_en[NumRegions];
  int c_base[NumRegions];
  int c_size[NumRegions];
  bit c_rd[NumRegions];
  bit c_pg[NumRegions];
  bit c_er[NumRegions];

  typedef struct {
    bit sel;   // 0: dut0 (scan), 1: dut1 (HW bypass)
    int cfg;
    bit sw;
    int op;
    int page;
    int dly;   // flash_done delay after first ISSUE cycle
    int rise;  // cycle of first flash_req, -1 if never
    int ack;
    int err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_cfg();
    for (int k = 0; k < NumRegions; k++) begin
      region_en[k] = c_en[k];
      rd_en[k]     = c_rd[k];
      prog_en[k]   = c_pg[k];
      erase_en[k]  = c_er[k];
      region_base[k*PageW +: PageW]         = PageW'(c_base[k]);
      region_size[k*(PageW+1) +: (PageW+1)] = (PageW+1)'(c_size[k]);
    end
  endtask

  // Preset 0: r0 0x10+0x10 read-only, r1 0x00+0x40 all, r2 0xF0+0x10 all, r3 size 0.
  // Preset 1: same with r0 disabled.
  task automatic set_preset(input int id);
    c_en   = '{1, 1, 1, 1};
    c_base = '{'h10, 'h00, 'hF0, 'h80};
    c_size = '{'h10, 'h40, 'h10, 0};
    c_rd   = '{1, 1, 1, 1};
    c_pg   = '{0, 1, 1, 1};
    c_er   = '{0, 1, 1, 1};
    if (id == 1) c_en[0] = 1'b0;
    apply_cfg();
  endtask

  task automatic drive_req(input bit sel, input bit sw, input bit v, input logic [1:0] op,
                           input logic [PageW-1:0] page);
    if (!sel) begin
      if (sw) begin bus0.sw_req_i = v; bus0.sw_op_i = op; bus0.sw_page_i = page; end
      else    begin bus0.hw_req_i = v; bus0.hw_op_i = op; bus0.hw_page_i = page; end
    end else begin
      if (sw) begin bus1.sw_req_i = v; bus1.sw_op_i = op; bus1.sw_page_i = page; end
      else    begin bus1.hw_req_i = v; bus1.hw_op_i = op; bus1.hw_page_i = page; end
    end
  endtask

  task automatic drive_done(input bit sel, input bit v);
    if (!sel) bus0.flash_done_i = v;
    else      bus1.flash_done_i = v;
  endtask

  function automatic int get_freq(input bit sel);
    return sel ? int'(bus1.flash_req_o) : int'(bus0.flash_req_o);
  endfunction

  function automatic int get_ack(input bit sel, input bit sw);
    if (!sel) return sw ? int'(bus0.sw_ack_o) : int'(bus0.hw_ack_o);
    return sw ? int'(bus1.sw_ack_o) : int'(bus1.hw_ack_o);
  endfunction

  function automatic int get_err(input bit sel, input bit sw);
    if (!sel) return sw ? int'(bus0.sw_err_o) : int'(bus0.hw_err_o);
    return sw ? int'(bus1.sw_err_o) : int'(bus1.hw_err_o);
  endfunction

  function automatic int get_op(input bit sel);
    return sel ? int'(bus1.flash_op_o) : int'(bus0.flash_op_o);
  endfunction

  function automatic int get_page(input bit sel);
    return sel ? int'(bus1.flash_page_o) : int'(bus0.flash_page_o);
  endfunction

  // One request from IDLE; cycle 0 is the grant cycle. Times are relative to it.
  task automatic run_txn(input bit sel, input bit sw, input int op, input int page,
                         input int dly, output int rise, output int ackc, output int err);
    rise = -1;
    ackc = -1;
    err  = 0;
    drive_req(sel, sw, 1'b1, 2'(op), PageW'(page));
    for (int c = 0; c < 64; c++) begin
      drive_done(sel, 1'b0);
      if (get_freq(sel) != 0) begin
        if (rise < 0) begin
          rise = c;
          check("flash_op", get_op(sel), op);
          check("flash_page", get_page(sel), page);
        end
        if (c - rise == dly) drive_done(sel, 1'b1);
      end
      if (get_ack(sel, sw) != 0) begin
        ackc = c;
        err  = get_err(sel, sw);
      end
      tick();
      if (ackc >= 0) break;
    end
    drive_req(sel, sw, 1'b0, 2'(op), PageW'(page));
    drive_done(sel, 1'b0);
  endtask

  // Reference: first enabled region containing the page decides; one region per cycle.
  function automatic void model(input bit attr, input bit sw, input int op, input int page,
                                input int dly, output int rise, output int ackc,
                                output int err);
    rise = -1;
    if (attr && !sw) begin
      if (op == 3) begin ackc = 1; err = 1; end
      else begin rise = 1; ackc = 2 + dly; err = 0; end
      return;
    end
    if (op == 3) begin ackc = 2; err = 1; return; end
    for (int k = 0; k < NumRegions; k++) begin
      if (c_en[k] && c_base[k] <= page && page < c_base[k] + c_size[k]) begin
        bit ok;
        ok = (op == 0) ? c_rd[k] : (op == 1) ? c_pg[k] : c_er[k];
        if (ok) begin rise = 2 + k; ackc = rise + dly + 1; err = 0; end
        else begin ackc = 2 + k; err = 1; end
        return;
      end
    end
    ackc = 1 + NumRegions;
    err  = 1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int rise, ackc, err, er, ea, ee;
    int order[$];
    int acyc[$];
    int acks;
    int seen;

    bus0.hw_req_i = 0; bus0.hw_op_i = 0; bus0.hw_page_i = 0;
    bus0.sw_req_i = 0; bus0.sw_op_i = 0; bus0.sw_page_i = 0; bus0.flash_done_i = 0;
    bus1.hw_req_i = 0; bus1.hw_op_i = 0; bus1.hw_page_i = 0;
    bus1.sw_req_i = 0; bus1.sw_op_i = 0; bus1.sw_page_i = 0; bus1.flash_done_i = 0;
    set_preset(0);
    do_reset();

    // Reset state.
    check("rst_busy0", busy0, 0);
    check("rst_busy1", busy1, 0);
    check("rst_flash_req", bus0.flash_req_o, 0);
    check("rst_flash_op", bus0.flash_op_o, 0);
    check("rst_flash_page", bus0.flash_page_o, 0);
    check("rst_hw_ack", bus0.hw_ack_o, 0);
    check("rst_sw_ack", bus0.sw_ack_o, 0);

    // sel, cfg, sw, op, page, dly, rise, ack, err
    vecs.push_back('{0, 0, 1, 0, 'h15, 2,  2, 5, 0}); // read hit r0
    vecs.push_back('{0, 0, 1, 1, 'h12, 0, -1, 2, 1}); // prog denied r0
    vecs.push_back('{0, 0, 1, 2, 'h18, 0, -1, 2, 1}); // erase: r0 first hit denies
    vecs.push_back('{0, 0, 1, 2, 'h20, 0,  3, 4, 0}); // r0 upper boundary miss, r1 permits
    vecs.push_back('{0, 0, 0, 0, 'hFF, 1,  4, 6, 0}); // top page in r2
    vecs.push_back('{0, 0, 1, 0, 'h80, 0, -1, 5, 1}); // size 0 region misses, full miss
    vecs.push_back('{0, 0, 0, 3, 'h15, 0, -1, 2, 1}); // reserved op
    vecs.push_back('{0, 0, 0, 0, 'h0F, 0,  3, 4, 0}); // below r0 base
    vecs.push_back('{0, 0, 1, 1, 'h3F, 3,  3, 7, 0}); // last page of r1, slow done
    vecs.push_back('{0, 0, 0, 0, 'h40, 0, -1, 5, 1}); // one past r1
    vecs.push_back('{0, 1, 1, 1, 'h12, 0,  3, 4, 0}); // r0 disabled, r1 permits
    vecs.push_back('{1, 0, 0, 0, 'h80, 1,  1, 3, 0}); // HW bypass, unmapped page
    vecs.push_back('{1, 0, 0, 3, 'h80, 0, -1, 1, 1}); // HW bypass, reserved op
    vecs.push_back('{1, 0, 1, 0, 'h80, 0, -1, 5, 1}); // SW still scanned
    vecs.push_back('{1, 0, 0, 1, 'h12, 0,  1, 2, 0}); // HW bypass ignores r0 deny

    foreach (vecs[i]) begin
      set_preset(vecs[i].cfg);
      run_txn(vecs[i].sel, vecs[i].sw, vecs[i].op, vecs[i].page, vecs[i].dly, rise, ackc, err);
      check($sformatf("vec%0d_rise", i), rise, vecs[i].rise);
      check($sformatf("vec%0d_ack", i), ackc, vecs[i].ack);
      check($sformatf("vec%0d_err", i), err, vecs[i].err);
    end

    // Arbitration: both held, HW wins first tie after reset, then alternate every 4 cycles.
    set_preset(0);
    do_reset();
    drive_req(0, 0, 1'b1, 2'd0, 8'h15);
    drive_req(0, 1, 1'b1, 2'd0, 8'h16);
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      drive_done(0, bus0.flash_req_o);
      if (bus0.hw_ack_o) begin order.push_back(0); acyc.push_back(c); end
      if (bus0.sw_ack_o) begin order.push_back(1); acyc.push_back(c); end
      tick();
    end
    drive_req(0, 0, 1'b0, 2'd0, 8'h15);
    drive_req(0, 1, 1'b0, 2'd0, 8'h16);
    drive_done(0, 1'b0);
    tick();
    check("arb_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      check("arb_order", (i < order.size()) ? order[i] : -1, i % 2);
    check("arb_first_ack", (acyc.size() > 0) ? acyc[0] : -1, 3);
    for (int i = 1; i < 4; i++)
      check("arb_spacing", (i < acyc.size()) ? acyc[i] - acyc[i-1] : -1, 4);

    // Reset while in ISSUE: request abandoned, no ack, next request completes.
    seen = 0;
    drive_req(0, 1, 1'b1, 2'd0, 8'h15);
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick();
      if (bus0.flash_req_o) seen = 1;
    end
    check("issue_reached", seen, 1);
    tick();
    tick();
    check("issue_held", bus0.flash_req_o, 1);
    rst = 1'b1;
    drive_req(0, 1, 1'b0, 2'd0, 8'h15);
    tick();
    rst = 1'b0;
    check("midrst_flash_req", bus0.flash_req_o, 0);
    check("midrst_busy", busy0, 0);
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      acks += int'(bus0.sw_ack_o) + int'(bus0.hw_ack_o);
      tick();
    end
    check("midrst_no_ack", acks, 0);
    run_txn(0, 1, 0, 'h15, 0, rise, ackc, err);
    check("post_rst_rise", rise, 2);
    check("post_rst_ack", ackc, 3);
    check("post_rst_err", err, 0);

    // Randomized transactions against the model.
    for (int t = 0; t < 150; t++) begin
      bit sel, sw;
      int op, page, dly;
      for (int k = 0; k < NumRegions; k++) begin
        c_en[k]   = ($urandom_range(0, 3) != 0);
        c_base[k] = $urandom_range(0, 255);
        c_size[k] = $urandom_range(0, 4) == 0 ? 0 : $urandom_range(1, 96);
        c_rd[k]   = $urandom_range(0, 1) != 0;
        c_pg[k]   = $urandom_range(0, 1) != 0;
        c_er[k]   = $urandom_range(0, 1) != 0;
      end
      apply_cfg();
      sel  = $urandom_range(0, 1) != 0;
      sw   = $urandom_range(0, 1) != 0;
      op   = $urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2);
      page = $urandom_range(0, 255);
      if ($urandom_range(0, 1) != 0) begin
        int r;
        r    = $urandom_range(0, NumRegions - 1);
        page = (c_base[r] + $urandom_range(0, 20)) % 256;
      end
      dly  = $urandom_range(0, 3);
      model(sel, sw, op, page, dly, er, ea, ee);
      run_txn(sel, sw, op, page, dly, rise, ackc, err);
      check($sformatf("rand%0d_rise", t), rise, er);
      check($sformatf("rand%0d_ack", t), ackc, ea);
      check($sformatf("rand%0d_err", t), err, ee);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
